// File: rtl/clusterv_sram_pkg.sv
// Shared constants and helpers for the cluster banked SRAM.
// The macro geometry is fixed; the bank count is a top-level parameter.
package clusterv_sram_pkg;

  localparam int MACRO_AW    = 10;
  localparam int MACRO_DW    = 32;
  localparam int MACRO_BYTES = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bank index is everything above the macro word address.
  function automatic logic [7:0] bank_index(input logic [31:0] addr);
    return 8'(addr >> MACRO_AW);
  endfunction

endpackage

// File: rtl/clusterv_sram_bank.sv
// One SRAM macro with its active-low select and write-enable gating
// derived from per-bank select strobes supplied by the top-level decode.
module clusterv_sram_bank
  import clusterv_sram_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire                     vccd1,
  inout  wire                     vssd1,
`endif
  input  logic                    i_clk,
  input  logic                    i_sel0,
  input  logic                    i_we,
  input  logic [MACRO_BYTES-1:0]  i_wmask,
  input  logic [MACRO_AW-1:0]     i_addr0,
  input  logic [MACRO_DW-1:0]     i_wdata,
  output logic [MACRO_DW-1:0]     o_rdata0,
  input  logic                    i_sel1,
  input  logic [MACRO_AW-1:0]     i_addr1,
  output logic [MACRO_DW-1:0]     o_rdata1
);

  logic w_csb0;
  logic w_web0;
  logic w_csb1;

  assign w_csb0 = ~i_sel0;
  assign w_web0 = ~i_we;
  assign w_csb1 = ~i_sel1;

  sky130_sram_4kbyte_1rw1r_32x1024_8 u_macro (
`ifdef USE_POWER_PINS
    .vccd1  (vccd1),
    .vssd1  (vssd1),
`endif
    .clk0   (i_clk),
    .csb0   (w_csb0),
    .web0   (w_web0),
    .wmask0 (i_wmask),
    .addr0  (i_addr0),
    .din0   (i_wdata),
    .dout0  (o_rdata0),
    .clk1   (i_clk),
    .csb1   (w_csb1),
    .addr1  (i_addr1),
    .dout1  (o_rdata1)
  );

endmodule

// File: rtl/sky130_sram_4kbyte_1rw1r_32x1024_8.sv
// Behavioural stand-in for the 1024x32 1RW+1R macro: synchronous,
// active-low selects, per-byte write mask, one-cycle registered read data.
module sky130_sram_4kbyte_1rw1r_32x1024_8 (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [9:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [9:0]  addr1,
  output logic [31:0] dout1
);

  logic [31:0] r_mem [1024];

  // Read/write port: masked byte writes, otherwise a registered read.
  always_ff @(posedge clk0) begin
    if (!csb0 && !web0) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask0[k]) r_mem[addr0][8*k +: 8] <= din0[8*k +: 8];
      end
    end else if (!csb0) begin
      dout0 <= r_mem[addr0];
    end
  end

  // Read-only port.
  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= r_mem[addr1];
  end

endmodule

// File: rtl/clusterv_banked_sram.sv
// Multi-bank cluster main memory: port 0 read/write, port 1 read-only,
// with same-word conflict stalling, read-data hold and out-of-range reporting.
module clusterv_banked_sram
  import clusterv_sram_pkg::*;
#(
  parameter  int NUM_BANKS  = 4,
  localparam int BANK_SEL_W = (clog2(NUM_BANKS) < 1) ? 1 : clog2(NUM_BANKS),
  localparam int ADDR_W     = BANK_SEL_W + MACRO_AW
) (
`ifdef USE_POWER_PINS
  inout  wire                    vccd1,
  inout  wire                    vssd1,
`endif
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      t0_addr,
  input  logic                   t0_read_en,
  input  logic                   t0_write_en,
  input  logic [MACRO_BYTES-1:0] t0_byte_en,
  input  logic [MACRO_DW-1:0]    t0_write_data,
  output logic                   t0_ready,
  output logic                   t0_read_valid,
  output logic [MACRO_DW-1:0]    t0_read_data,
  input  logic [ADDR_W-1:0]      t1_addr,
  input  logic                   t1_read_en,
  output logic                   t1_ready,
  output logic                   t1_read_valid,
  output logic [MACRO_DW-1:0]    t1_read_data,
  output logic                   oob_err
);

  logic [7:0]          w_t0_bank;
  logic [7:0]          w_t1_bank;
  logic                w_t0_oob;
  logic                w_t1_oob;
  logic                w_conflict;
  logic                w_t0_acc;
  logic                w_t0_rd;
  logic                w_t1_acc;
  logic [NUM_BANKS-1:0] w_sel0;
  logic [NUM_BANKS-1:0] w_sel1;
  logic [MACRO_DW-1:0] w_dout0 [NUM_BANKS];
  logic [MACRO_DW-1:0] w_dout1 [NUM_BANKS];
  logic [MACRO_DW-1:0] w_mux0;
  logic [MACRO_DW-1:0] w_mux1;
  logic [MACRO_DW-1:0] w_rd0;
  logic [MACRO_DW-1:0] w_rd1;

  logic [1:0]          r_rd_valid;
  logic [1:0]          r_oob_q;
  logic [7:0]          r_bank_q0;
  logic [7:0]          r_bank_q1;
  logic [MACRO_DW-1:0] r_hold0;
  logic [MACRO_DW-1:0] r_hold1;
  logic                r_oob_err;

  assign w_t0_bank = bank_index(32'(t0_addr));
  assign w_t1_bank = bank_index(32'(t1_addr));
  assign w_t0_oob  = (w_t0_bank >= 8'(NUM_BANKS));
  assign w_t1_oob  = (w_t1_bank >= 8'(NUM_BANKS));

  // Read-during-write on the same word is undefined in the macro, so port 1 waits.
  assign w_conflict = t0_write_en & t1_read_en & (t0_addr == t1_addr);

  assign t0_ready = ~reset;
  assign t1_ready = ~reset & ~w_conflict;
  assign w_t0_acc = t0_ready & (t0_read_en | t0_write_en);
  assign w_t0_rd  = w_t0_acc & ~t0_write_en;
  assign w_t1_acc = t1_ready & t1_read_en;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_sel0[b] = w_t0_acc & ~w_t0_oob & (w_t0_bank == 8'(b));
    assign w_sel1[b] = w_t1_acc & ~w_t1_oob & (w_t1_bank == 8'(b));

    clusterv_sram_bank u_bank (
`ifdef USE_POWER_PINS
      .vccd1    (vccd1),
      .vssd1    (vssd1),
`endif
      .i_clk    (clock),
      .i_sel0   (w_sel0[b]),
      .i_we     (t0_write_en),
      .i_wmask  (t0_byte_en),
      .i_addr0  (t0_addr[MACRO_AW-1:0]),
      .i_wdata  (t0_write_data),
      .o_rdata0 (w_dout0[b]),
      .i_sel1   (w_sel1[b]),
      .i_addr1  (t1_addr[MACRO_AW-1:0]),
      .o_rdata1 (w_dout1[b])
    );
  end

  // Steer the bank captured at acceptance; out-of-range reads return zero.
  always_comb begin
    w_mux0 = 32'h0;
    w_mux1 = 32'h0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_mux0 = (r_bank_q0 == 8'(b)) ? w_dout0[b] : w_mux0;
      w_mux1 = (r_bank_q1 == 8'(b)) ? w_dout1[b] : w_mux1;
    end
    if (r_oob_q[0]) begin
      w_rd0 = 32'h0;
    end else begin
      w_rd0 = w_mux0;
    end
    if (r_oob_q[1]) begin
      w_rd1 = 32'h0;
    end else begin
      w_rd1 = w_mux1;
    end
  end

  // Read pipelines, hold registers and the out-of-range pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 2'b00;
      r_oob_q    <= 2'b00;
      r_bank_q0  <= 8'h00;
      r_bank_q1  <= 8'h00;
      r_hold0    <= 32'h0;
      r_hold1    <= 32'h0;
      r_oob_err  <= 1'b0;
    end else begin
      r_rd_valid <= {w_t1_acc, w_t0_rd};
      r_oob_err  <= (w_t0_acc & w_t0_oob) | (w_t1_acc & w_t1_oob);
      if (w_t0_rd) begin
        r_bank_q0  <= w_t0_bank;
        r_oob_q[0] <= w_t0_oob;
      end
      if (w_t1_acc) begin
        r_bank_q1  <= w_t1_bank;
        r_oob_q[1] <= w_t1_oob;
      end
      if (r_rd_valid[0]) r_hold0 <= w_rd0;
      if (r_rd_valid[1]) r_hold1 <= w_rd1;
    end
  end

  // An in-flight read caught by reset must never be seen as valid.
  assign t0_read_valid = r_rd_valid[0] & ~reset;
  assign t1_read_valid = r_rd_valid[1] & ~reset;
  assign t0_read_data  = reset ? 32'h0 : (r_rd_valid[0] ? w_rd0 : r_hold0);
  assign t1_read_data  = reset ? 32'h0 : (r_rd_valid[1] ? w_rd1 : r_hold1);
  assign oob_err       = r_oob_err & ~reset;

endmodule

// File: tb/tb_clusterv_banked_sram.sv
// Scoreboard bench for clusterv_banked_sram with three banks, so the
// fourth bank index exercises the out-of-range path.
module tb_clusterv_banked_sram;

  localparam int NB = 3;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] t0_addr = 12'h0;
  logic        t0_read_en = 1'b0;
  logic        t0_write_en = 1'b0;
  logic [3:0]  t0_byte_en = 4'h0;
  logic [31:0] t0_write_data = 32'h0;
  logic        t0_ready;
  logic        t0_read_valid;
  logic [31:0] t0_read_data;
  logic [11:0] t1_addr = 12'h0;
  logic        t1_read_en = 1'b0;
  logic        t1_ready;
  logic        t1_read_valid;
  logic [31:0] t1_read_data;
  logic        oob_err;

  clusterv_banked_sram #(.NUM_BANKS(NB)) dut (
    .clock(clk), .reset(reset),
    .t0_addr(t0_addr), .t0_read_en(t0_read_en), .t0_write_en(t0_write_en),
    .t0_byte_en(t0_byte_en), .t0_write_data(t0_write_data), .t0_ready(t0_ready),
    .t0_read_valid(t0_read_valid), .t0_read_data(t0_read_data),
    .t1_addr(t1_addr), .t1_read_en(t1_read_en), .t1_ready(t1_ready),
    .t1_read_valid(t1_read_valid), .t1_read_data(t1_read_data),
    .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [NB*1024];
  exp_t q0[$];
  exp_t q1[$];
  int   qo[$];
  logic [31:0] last0 = 32'h0;
  logic [31:0] last1 = 32'h0;
  logic        m_rdy1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_oob(input logic [11:0] a);
    return int'(a[11:10]) >= NB;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (is_oob(a)) return 32'h0;
    return mem[int'(a)];
  endfunction

  // One bus cycle: drive, check handshake against the rules, update the model.
  task automatic step(input logic rst, input logic we, input logic re0,
                      input logic [11:0] a0, input logic [3:0] be,
                      input logic [31:0] wd, input logic re1, input logic [11:0] a1);
    logic er0, er1, acc0, acc1;
    @(posedge clk);
    #1;
    reset = rst; t0_write_en = we; t0_read_en = re0; t0_addr = a0;
    t0_byte_en = be; t0_write_data = wd; t1_read_en = re1; t1_addr = a1;
    #1;
    er0 = !rst;
    er1 = !rst && !(we && re1 && (a0 == a1));
    chk("t0_ready", t0_ready, er0);
    chk("t1_ready", t1_ready, er1);
    m_rdy1 = er1;
    acc0 = er0 && (we || re0);
    acc1 = er1 && re1;
    if (acc1) q1.push_back('{model_read(a1), cyc + 1});
    if (acc0 && !we) q0.push_back('{model_read(a0), cyc + 1});
    if ((acc0 && is_oob(a0)) || (acc1 && is_oob(a1))) qo.push_back(cyc + 1);
    if (acc0 && we && !is_oob(a0)) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[int'(a0)][8*k +: 8] = wd[8*k +: 8];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0);
  endtask

  // Monitor: pops expected reads when due and checks valid, data, hold and oob pulse.
  always @(negedge clk) begin
    logic ev0, ev1, eo;
    exp_t e;
    if (reset) begin
      chk("rst_valid0", t0_read_valid, 1'b0);
      chk("rst_valid1", t1_read_valid, 1'b0);
      chk("rst_data0", t0_read_data, 32'h0);
      chk("rst_data1", t1_read_data, 32'h0);
      chk("rst_oob", oob_err, 1'b0);
      q0.delete(); q1.delete(); qo.delete();
      last0 = 32'h0; last1 = 32'h0;
    end else begin
      ev0 = (q0.size() != 0) && (q0[0].due == cyc);
      ev1 = (q1.size() != 0) && (q1[0].due == cyc);
      eo  = (qo.size() != 0) && (qo[0] == cyc);
      chk("p0_valid", t0_read_valid, ev0);
      chk("p1_valid", t1_read_valid, ev1);
      chk("oob_err", oob_err, eo);
      if (eo) void'(qo.pop_front());
      if (ev0) begin
        e = q0.pop_front();
        chk("p0_data", t0_read_data, e.data);
        last0 = e.data;
      end else begin
        chk("p0_hold", t0_read_data, last0);
      end
      if (ev1) begin
        e = q1.pop_front();
        chk("p1_data", t1_read_data, e.data);
        last1 = e.data;
      end else begin
        chk("p1_hold", t1_read_data, last1);
      end
    end
  end

  function automatic logic [11:0] pool_addr();
    return {2'($urandom_range(0, 3)), 7'd0, 3'($urandom_range(0, 7))};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic        rst, we, re0, p1re;
    logic [11:0] a0, p1a;
    step(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0);
    step(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0);

    // Full write then port-0 read.
    step(1'b0, 1'b1, 1'b0, 12'h005, 4'hF, 32'hDEADBEEF, 1'b0, 12'h0);
    step(1'b0, 1'b0, 1'b1, 12'h005, 4'h0, 32'h0, 1'b0, 12'h0);
    idle(2);

    // Byte-masked overwrite, read on port 1, then hold.
    step(1'b0, 1'b1, 1'b0, 12'h010, 4'hF, 32'h11223344, 1'b0, 12'h0);
    step(1'b0, 1'b1, 1'b0, 12'h010, 4'h1, 32'h000000AA, 1'b0, 12'h0);
    step(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'h010);
    idle(3);

    // Same-word conflict stalls port 1; neighbouring word does not.
    step(1'b0, 1'b1, 1'b0, 12'h406, 4'hF, 32'h55667788, 1'b0, 12'h0);
    step(1'b0, 1'b1, 1'b0, 12'h405, 4'hF, 32'hCAFEF00D, 1'b1, 12'h405);
    step(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'h405);
    step(1'b0, 1'b1, 1'b0, 12'h405, 4'hF, 32'h0BADF00D, 1'b1, 12'h406);
    idle(2);

    // Out-of-range write and read.
    step(1'b0, 1'b1, 1'b0, 12'hC00, 4'hF, 32'h12345678, 1'b0, 12'h0);
    step(1'b0, 1'b0, 1'b1, 12'hC00, 4'h0, 32'h0, 1'b0, 12'h0);
    step(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'hC05);
    idle(2);

    // Last word of each bank, then back-to-back reads.
    for (int b = 0; b < 4; b++)
      step(1'b0, 1'b1, 1'b0, {2'(b), 10'h3FF}, 4'hF, 32'(b), 1'b0, 12'h0);
    for (int b = 0; b < 4; b++)
      step(1'b0, 1'b0, 1'b1, {2'(b), 10'h3FF}, 4'h0, 32'h0, 1'b1, {2'(3 - b), 10'h3FF});
    idle(2);

    // Reset right after an accepted read; contents survive.
    step(1'b0, 1'b0, 1'b1, 12'h005, 4'h0, 32'h0, 1'b1, 12'h010);
    step(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 12'h005, 4'h0, 32'h0, 1'b1, 12'h405);
    idle(2);

    // Seed a small address pool in every real bank.
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < 8; w++)
        step(1'b0, 1'b1, 1'b0, {2'(b), 7'd0, 3'(w)}, 4'hF, $urandom, 1'b0, 12'h0);

    // Random traffic; a stalled port-1 request is held until accepted.
    p1re = 1'b0;
    p1a  = 12'h0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 2) == 0);
      re0 = 1'($urandom_range(0, 1));
      a0  = pool_addr();
      if (!(p1re && !m_rdy1)) begin
        p1re = 1'($urandom_range(0, 1));
        p1a  = pool_addr();
      end
      if ($urandom_range(0, 4) == 0) a0 = p1a;
      step(rst, we, re0, a0, 4'($urandom), $urandom, p1re, p1a);
    end
    idle(4);

    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);
    chk("drain_oob", qo.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
